// File: rtl/accel_core_pkg.sv
// accel_core_pkg: shared types and constants for the accelerator core.
//   t_sched_state   : layer scheduler FSM states
//   t_slot_state    : per weight-buffer slot state
//   SCHED_NUM_SLOTS : number of weight-buffer slots (w1..w3)
package accel_core_pkg;

   localparam int unsigned SCHED_NUM_SLOTS = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } t_sched_state;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_LOADED,
      SLOT_ACTIVE
   } t_slot_state;

endpackage

// File: rtl/accel_core_slot_pick.sv
// accel_core_slot_pick: combinational slot selector.
//   free_vec_i    : per-slot FREE flags
//   loaded_vec_i  : per-slot LOADED flags
//   tags_i        : per-slot neuron tags, slot s at [s*NEURON_W +: NEURON_W]
//   disp_cnt_i    : neuron index due for dispatch
//   free_found_o / free_idx_o   : lowest-index FREE slot
//   match_found_o / match_idx_o : lowest LOADED slot whose tag equals disp_cnt_i
module accel_core_slot_pick
   import accel_core_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = SCHED_NUM_SLOTS,
   parameter int unsigned NEURON_W  = 8,
   parameter int unsigned IDX_W     = 2
) (
   input  logic [NUM_SLOTS-1:0]          free_vec_i,
   input  logic [NUM_SLOTS-1:0]          loaded_vec_i,
   input  logic [NUM_SLOTS*NEURON_W-1:0] tags_i,
   input  logic [NEURON_W-1:0]           disp_cnt_i,
   output logic                          free_found_o,
   output logic [IDX_W-1:0]              free_idx_o,
   output logic                          match_found_o,
   output logic [IDX_W-1:0]              match_idx_o
);

   always_comb begin
      free_found_o  = 1'b0;
      free_idx_o    = '0;
      match_found_o = 1'b0;
      match_idx_o   = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (!free_found_o && free_vec_i[i]) begin
            free_found_o = 1'b1;
            free_idx_o   = IDX_W'(i);
         end
         if (!match_found_o && loaded_vec_i[i] &&
             (tags_i[i*NEURON_W +: NEURON_W] == disp_cnt_i)) begin
            match_found_o = 1'b1;
            match_idx_o   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/accel_core_weight_sched.sv
// accel_core_weight_sched: layer-level scheduler for the multiply datapath.
// Hands free weight slots to the loader, dispatches loaded slots to the
// multiply engine in ascending neuron order, reclaims them on release and
// ends the layer with done_layer / move_out_to_in.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   layer_start_i, layer_neuron_num_i         : layer request (IDLE only)
//   load_ready_o, load_valid_i, load_slot_o,
//   load_neuron_idx_o                         : weight loader handshake
//   in_use_o, release_i                       : per-slot handshake with mul top
//   in_use_by_accel_o, done_layer_o,
//   move_out_to_in_o, busy_o, protocol_err_o  : status
// Optional feature: define ACCEL_SCHED_TIMEOUT_EN for a release watchdog.
module accel_core_weight_sched
   import accel_core_pkg::*;
#(
   parameter int unsigned NUM_SLOTS      = SCHED_NUM_SLOTS,
   parameter int unsigned NEURON_W       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         layer_start_i,
   input  logic [NEURON_W-1:0]          layer_neuron_num_i,
   output logic                         load_ready_o,
   input  logic                         load_valid_i,
   output logic [$clog2(NUM_SLOTS)-1:0] load_slot_o,
   output logic [NEURON_W-1:0]          load_neuron_idx_o,
   output logic [NUM_SLOTS-1:0]         in_use_o,
   input  logic [NUM_SLOTS-1:0]         release_i,
   output logic                         in_use_by_accel_o,
   output logic                         done_layer_o,
   output logic                         move_out_to_in_o,
   output logic                         busy_o,
   output logic                         protocol_err_o
);

   localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   t_sched_state        state_q, state_d;
   t_slot_state         slot_st_q [NUM_SLOTS];
   t_slot_state         slot_st_d [NUM_SLOTS];
   logic [NEURON_W-1:0] tag_q [NUM_SLOTS];
   logic [NEURON_W-1:0] tag_d [NUM_SLOTS];
   logic [NEURON_W-1:0] load_cnt_q, load_cnt_d;
   logic [NEURON_W-1:0] disp_cnt_q, disp_cnt_d;
   logic [NEURON_W-1:0] done_cnt_q, done_cnt_d;
   logic [NEURON_W-1:0] num_q, num_d;
   logic                err_q, err_d;

`ifdef ACCEL_SCHED_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wdog_q, wdog_d;
`endif

   logic [NUM_SLOTS-1:0]          free_vec, loaded_vec, active_vec;
   logic [NUM_SLOTS*NEURON_W-1:0] tags_flat;
   logic                          free_found, match_found;
   logic [IDX_W-1:0]              free_idx, match_idx;
   logic                          load_accept, err_set;

   always_comb begin
      free_vec   = '0;
      loaded_vec = '0;
      active_vec = '0;
      tags_flat  = '0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
         free_vec[s]                      = (slot_st_q[s] == SLOT_FREE);
         loaded_vec[s]                    = (slot_st_q[s] == SLOT_LOADED);
         active_vec[s]                    = (slot_st_q[s] == SLOT_ACTIVE);
         tags_flat[s*NEURON_W +: NEURON_W] = tag_q[s];
      end
   end

   accel_core_slot_pick #(
      .NUM_SLOTS (NUM_SLOTS),
      .NEURON_W  (NEURON_W),
      .IDX_W     (IDX_W)
   ) u_pick (
      .free_vec_i    (free_vec),
      .loaded_vec_i  (loaded_vec),
      .tags_i        (tags_flat),
      .disp_cnt_i    (disp_cnt_q),
      .free_found_o  (free_found),
      .free_idx_o    (free_idx),
      .match_found_o (match_found),
      .match_idx_o   (match_idx)
   );

   // Outputs decode registered state only.
   assign load_ready_o      = (state_q == S_RUN) && free_found && (load_cnt_q < num_q);
   assign load_slot_o       = free_idx;
   assign load_neuron_idx_o = load_cnt_q;
   assign in_use_o          = active_vec;
   assign in_use_by_accel_o = (state_q != S_IDLE);
   assign busy_o            = (state_q != S_IDLE);
   assign done_layer_o      = (state_q == S_DONE);
   assign move_out_to_in_o  = (state_q == S_DONE);
   assign protocol_err_o    = err_q;

   assign load_accept = load_valid_i && load_ready_o;

   always_comb begin
      state_d    = state_q;
      slot_st_d  = slot_st_q;
      tag_d      = tag_q;
      load_cnt_d = load_cnt_q;
      disp_cnt_d = disp_cnt_q;
      done_cnt_d = done_cnt_q;
      num_d      = num_q;
      err_set    = (load_valid_i && !load_ready_o) || (|(release_i & ~active_vec));
`ifdef ACCEL_SCHED_TIMEOUT_EN
      wdog_d     = '0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (layer_start_i) begin
               state_d    = S_RUN;
               load_cnt_d = '0;
               disp_cnt_d = '0;
               done_cnt_d = '0;
               num_d      = layer_neuron_num_i;
               for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                  slot_st_d[s] = SLOT_FREE;
               end
            end
         end
         S_RUN: begin
            if (done_cnt_q == num_q) begin
               state_d = S_DONE;
            end
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
               if (release_i[s] && active_vec[s]) begin
                  slot_st_d[s] = SLOT_FREE;
                  done_cnt_d   = done_cnt_d + 1'b1;
               end
            end
`ifdef ACCEL_SCHED_TIMEOUT_EN
            if ((|active_vec) && !(|(release_i & active_vec))) begin
               if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  err_set = 1'b1;
                  for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                     if (active_vec[s]) slot_st_d[s] = SLOT_FREE;
                  end
                  done_cnt_d = done_cnt_d + 1'b1;
               end else begin
                  wdog_d = wdog_q + 1'b1;
               end
            end
`endif
            if (load_accept) begin
               for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                  if (IDX_W'(s) == free_idx) begin
                     slot_st_d[s] = SLOT_LOADED;
                     tag_d[s]     = load_cnt_q;
                  end
               end
               load_cnt_d = load_cnt_q + 1'b1;
            end
            // A slot being loaded with the due neuron goes straight to ACTIVE
            // so an idle engine sees in_use one cycle after the load.
            if (!(|active_vec)) begin
               if (match_found) begin
                  for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                     if (IDX_W'(s) == match_idx) slot_st_d[s] = SLOT_ACTIVE;
                  end
                  disp_cnt_d = disp_cnt_q + 1'b1;
               end else if (load_accept && (load_cnt_q == disp_cnt_q)) begin
                  for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                     if (IDX_W'(s) == free_idx) slot_st_d[s] = SLOT_ACTIVE;
                  end
                  disp_cnt_d = disp_cnt_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if ((state_q == S_IDLE) && layer_start_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q | err_set;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            slot_st_q[s] <= SLOT_FREE;
            tag_q[s]     <= '0;
         end
         load_cnt_q <= '0;
         disp_cnt_q <= '0;
         done_cnt_q <= '0;
         num_q      <= '0;
         err_q      <= 1'b0;
`ifdef ACCEL_SCHED_TIMEOUT_EN
         wdog_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         slot_st_q  <= slot_st_d;
         tag_q      <= tag_d;
         load_cnt_q <= load_cnt_d;
         disp_cnt_q <= disp_cnt_d;
         done_cnt_q <= done_cnt_d;
         num_q      <= num_d;
         err_q      <= err_d;
`ifdef ACCEL_SCHED_TIMEOUT_EN
         wdog_q     <= wdog_d;
`endif
      end
   end

endmodule

// File: doc/accel_core_weight_sched.md
# accel_core_weight_sched

Layer-level scheduler for the accelerator core multiply datapath (`accel_core_mul_top`).
- Owns the three weight-buffer slots: hands free slots to the weight loader, dispatches loaded slots to the multiply engine one neuron at a time in ascending neuron order, and reclaims them on release.
- Holds the input vector in use for the layer's duration, then ends the layer with `done_layer` / `move_out_to_in`.
- Sits between the core's weight-loader/DMA and `accel_core_mul_top`.

## Interface
Parameters:
- NUM_SLOTS, 3, weight-buffer slots (matches w1..w3)
- NEURON_W, 8, width of neuron index/count
- TIMEOUT_CYCLES, 1024, watchdog limit (only with ACCEL_SCHED_TIMEOUT_EN)

Ports:
- Clock  in  1  single clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- layer_start  in  1  one-cycle pulse, begins a layer (sampled in IDLE only)
- layer_neuron_num  in  NEURON_W  neurons in layer, sampled with layer_start
- load_ready  out  1  a free slot is available for loading
- load_valid  in  1  loader has written slot `load_slot` with neuron `load_neuron_idx`
- load_slot  out  $clog2(NUM_SLOTS)  slot loader must write
- load_neuron_idx  out  NEURON_W  neuron index loader must write
- in_use  out  NUM_SLOTS  per-slot in_use to mul top, at most one bit set
- release  in  NUM_SLOTS  per-slot release from mul top
- in_use_by_accel  out  1  input vector owned by accelerator
- done_layer  out  1  one-cycle pulse, all neurons released
- move_out_to_in  out  1  one-cycle pulse coincident with done_layer
- busy  out  1  state != IDLE
- protocol_err  out  1  sticky; cleared by Rst or layer_start

## Operation
- Per-slot state: FREE, LOADED (tag = neuron idx), ACTIVE.
- Counters: load_cnt (next neuron to load), disp_cnt (next to dispatch), done_cnt (released); all NEURON_W bits.
- FSM:
  - IDLE -> RUN on layer_start: counters cleared, slots FREE, in_use_by_accel=1.
  - RUN -> DONE when done_cnt == neuron_num.
  - DONE -> IDLE after one cycle, pulsing done_layer and move_out_to_in; in_use_by_accel=0 from IDLE onward.
- Loading:
  - load_ready = RUN && any FREE slot && load_cnt < neuron_num.
  - load_slot = lowest-index FREE slot; load_neuron_idx = load_cnt.
  - On valid&&ready: slot -> LOADED with tag load_cnt, load_cnt++.
  - load_valid while !load_ready is ignored and sets protocol_err.
- Dispatch: when no slot is ACTIVE and a LOADED slot tag == disp_cnt, that slot -> ACTIVE, its in_use bit = 1 (level, held until release), disp_cnt++.
- Release:
  - release[s] with s ACTIVE -> s FREE, in_use[s]=0, done_cnt++.
  - release on a non-ACTIVE slot is ignored and sets protocol_err.
- neuron_num = 0: RUN exits to DONE on the first RUN cycle.
- layer_start outside IDLE: ignored.
- Rst mid-layer: everything returns to reset values immediately, with no done pulse.

## Timing
- Reset values: load_ready=0, load_slot=0, load_neuron_idx=0, in_use=0, in_use_by_accel=0, done_layer=0, move_out_to_in=0, busy=0, protocol_err=0.
- All outputs are registered or decoded from registered state only; there is no input-to-output combinational path.
- layer_start at edge t: busy, in_use_by_accel, load_ready high at t+1.
- Load accepted at edge t with the engine idle: in_use bit high at t+1.
- Release at edge t: in_use bit low at t+1. The next dispatch sees the cleared slot at t+1 and asserts in_use at t+2 (one-cycle bubble). The freed slot is offered on load_ready from t+1.
- Load and release in the same cycle on different slots: both take effect.
- Last release at edge t: done_layer and move_out_to_in high for exactly cycle t+2 (DONE). in_use_by_accel low at t+3.

## Configuration
- ACCEL_SCHED_TIMEOUT_EN defined: a watchdog counter runs while a slot is ACTIVE and clears on release. Reaching TIMEOUT_CYCLES sets protocol_err, forces the active slot FREE, counts it as done, and the layer continues.
- ACCEL_SCHED_TIMEOUT_EN undefined: no counter; the scheduler waits indefinitely for release.

## Structure
- accel_core_pkg gains:
  - t_sched_state enum (S_IDLE, S_RUN, S_DONE)
  - t_slot_state enum (SLOT_FREE, SLOT_LOADED, SLOT_ACTIVE)
  - SCHED_NUM_SLOTS constant
- One sub-module, accel_core_slot_pick: combinational lowest-index-FREE finder plus tag-match selector, returning found flag and index.

## Test plan
- neuron_num=3, loader always valid: slots 0,1,2 loaded with idx 0,1,2. in_use sequence 001, 010, 100, each released 20 cycles later. done_layer and move_out_to_in pulse once, 2 cycles after the third release.
- neuron_num=5: idx 3 and 4 reuse slots freed by idx 0 and 1. Dispatch order stays 0..4 and load_neuron_idx tracks load_cnt.
- Release at the same edge as a load to another slot: both accepted, done_cnt and load_cnt each +1, protocol_err=0.
- release[2] while slot 2 is FREE: protocol_err=1 and no counter changes. A subsequent layer_start clears protocol_err.
- neuron_num=0: done_layer pulses 2 cycles after layer_start. in_use never set, load_ready never high.
- Rst asserted while slot 1 is ACTIVE: next cycle all outputs at reset values and no done_layer. With ACCEL_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16 and release withheld: protocol_err=1 after 16 cycles and the layer completes.
